// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - round-robin merge of i-cache and d-cache SRAM-like ports onto one bridge port
// One transaction outstanding; the grant is held from the IDLE grant cycle until data_ok.
module cache_bus_arbiter #(
  parameter bit D_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] i_rdata,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t state;
  logic   gnt_d;
  logic   last_d;
  logic   g_req;
  logic   next_gnt_d;
  logic   g_addr_ok;
  logic   g_data_ok;

  assign g_req      = gnt_d ? d_req : i_req;
  // On conflict the side that did not win last time gets the bus.
  assign next_gnt_d = (d_req && i_req) ? ~last_d : d_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_d  <= 1'b0;
      last_d <= ~D_FIRST;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || i_req) begin
            gnt_d  <= next_gnt_d;
            last_d <= next_gnt_d;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            state <= m_data_ok ? IDLE : DATA;
          end else if (!g_req) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (m_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_req     = (state == ADDR) && g_req;
    m_wr      = gnt_d ? d_wr    : i_wr;
    m_size    = gnt_d ? d_size  : i_size;
    m_addr    = gnt_d ? d_addr  : i_addr;
    m_wdata   = gnt_d ? d_wdata : i_wdata;
    g_addr_ok = (state == ADDR) && m_addr_ok;
    g_data_ok = ((state == ADDR) && m_addr_ok && m_data_ok) ||
                ((state == DATA) && m_data_ok);
    i_addr_ok = !gnt_d && g_addr_ok;
    i_data_ok = !gnt_d && g_data_ok;
    d_addr_ok = gnt_d && g_addr_ok;
    d_data_ok = gnt_d && g_data_ok;
    i_rdata   = m_rdata;
    d_rdata   = m_rdata;
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - directed bench with a transaction-level ownership model
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0, i_wr = 1'b0;
  logic [1:0]  i_size = 2'd2;
  logic [31:0] i_addr = 32'h1FC0_0000, i_wdata = 32'h1111_1111;
  logic [31:0] i_rdata;
  logic        i_addr_ok, i_data_ok;
  logic        d_req = 1'b0, d_wr = 1'b0;
  logic [1:0]  d_size = 2'd2;
  logic [31:0] d_addr = 32'h0, d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_addr_ok, d_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;

  int total = 0;
  int bad = 0;

  cache_bus_arbiter #(.D_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: who owns the bus (0 none, 1 i, 2 d), whether the bridge took the address,
  // who wins the next tie, and whose fields the shared port shows.
  int owner;
  bit accepted, prefer_d, fields_d;

  always @(negedge clk) begin
    logic oreq, ao, dk;
    if (rst) begin
      owner = 0; accepted = 0; prefer_d = 1'b1; fields_d = 0;
    end else begin
      oreq = (owner == 2) ? d_req : i_req;
      ao = 0; dk = 0;
      if (owner != 0 && !accepted) begin
        ao = m_addr_ok; dk = m_addr_ok && m_data_ok;
      end else if (owner != 0) begin
        dk = m_data_ok;
      end
      chk("m_req", m_req, (owner != 0 && !accepted) ? oreq : 1'b0);
      chk("i_addr_ok", i_addr_ok, (owner == 1) && ao);
      chk("i_data_ok", i_data_ok, (owner == 1) && dk);
      chk("d_addr_ok", d_addr_ok, (owner == 2) && ao);
      chk("d_data_ok", d_data_ok, (owner == 2) && dk);
      chk("m_wr", m_wr, fields_d ? d_wr : i_wr);
      chk("m_size", m_size, fields_d ? d_size : i_size);
      chk("m_addr", m_addr, fields_d ? d_addr : i_addr);
      chk("m_wdata", m_wdata, fields_d ? d_wdata : i_wdata);
      chk("i_rdata", i_rdata, m_rdata);
      chk("d_rdata", d_rdata, m_rdata);
      if (owner == 0) begin
        if (d_req && i_req) owner = prefer_d ? 2 : 1;
        else if (d_req) owner = 2;
        else if (i_req) owner = 1;
        if (owner != 0) begin
          fields_d = (owner == 2);
          prefer_d = (owner == 1);
        end
      end else if (!accepted) begin
        if (m_addr_ok) begin
          if (m_data_ok) owner = 0; else accepted = 1;
        end else if (!oreq) begin
          owner = 0;
        end
      end else if (m_data_ok) begin
        owner = 0; accepted = 0;
      end
      if (owner == 0) accepted = 0;
    end
  end

  string grants = "";
  always @(negedge clk) begin
    if (!rst && d_addr_ok) grants = {grants, "D"};
    if (!rst && i_addr_ok) grants = {grants, "I"};
  end

  task automatic step(input logic ir, input logic dr, input logic ma, input logic md,
                      input logic [31:0] rd, input logic r);
    @(posedge clk); #1;
    i_req = ir; d_req = dr; m_addr_ok = ma; m_data_ok = md; m_rdata = rd; rst = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    do_reset();
    chk("reset m_req", m_req, 1'b0);
    chk("reset d_addr_ok", d_addr_ok, 1'b0);

    // d read alone
    d_addr = 32'h1000_0040; d_wr = 0; d_size = 2;
    step(0, 1, 0, 0, 32'h0, 0);
    chk("t1 c0 m_req", m_req, 1'b0);
    step(0, 1, 0, 0, 32'h0, 0);
    chk("t1 c1 m_req", m_req, 1'b1);
    chk("t1 c1 m_addr", m_addr, 32'h1000_0040);
    step(0, 1, 1, 0, 32'h0, 0);
    chk("t1 c2 d_addr_ok", d_addr_ok, 1'b1);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("t1 c3 m_req", m_req, 1'b0);
    step(0, 0, 0, 1, 32'hCAFE_F00D, 0);
    chk("t1 c4 d_data_ok", d_data_ok, 1'b1);
    chk("t1 c4 d_rdata", d_rdata, 32'hCAFE_F00D);
    chk("t1 c4 i_data_ok", i_data_ok, 1'b0);
    step(0, 0, 0, 0, 32'h0, 0);

    // simultaneous requests: d first, then i with addr_ok and data_ok together
    do_reset();
    step(1, 1, 0, 0, 32'h0, 0);
    step(1, 1, 1, 0, 32'h0, 0);
    chk("t2 d_addr_ok", d_addr_ok, 1'b1);
    chk("t2 i_addr_ok early", i_addr_ok, 1'b0);
    step(1, 0, 0, 1, 32'h1234_5678, 0);
    chk("t2 d_data_ok", d_data_ok, 1'b1);
    chk("t2 i_addr_ok before idle", i_addr_ok, 1'b0);
    step(1, 0, 0, 0, 32'h0, 0);
    step(1, 0, 1, 1, 32'h8765_4321, 0);
    chk("t5 i_addr_ok", i_addr_ok, 1'b1);
    chk("t5 i_data_ok", i_data_ok, 1'b1);
    chk("t5 m_addr", m_addr, 32'h1FC0_0000);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("t5 idle m_req", m_req, 1'b0);

    // round robin with both sides always requesting
    do_reset();
    grants = "";
    for (int k = 0; k < 8; k++) step(1, 1, 1, 1, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 0);
    total++;
    if (grants != "DIDI") begin
      bad++;
      $display("FAIL t3 grant order: got %s want DIDI", grants);
    end

    // d byte write
    do_reset();
    d_wr = 1; d_size = 0; d_addr = 32'h1000_0003; d_wdata = 32'h0000_00AB;
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 1, 0, 32'h0, 0);
    chk("t4 m_wr", m_wr, 1'b1);
    chk("t4 m_size", m_size, 2'd0);
    chk("t4 m_addr", m_addr, 32'h1000_0003);
    chk("t4 m_wdata", m_wdata, 32'h0000_00AB);
    step(0, 0, 0, 0, 32'h0, 0);
    chk("t4 no early data_ok", d_data_ok, 1'b0);
    step(0, 0, 0, 1, 32'h0, 0);
    chk("t4 d_data_ok", d_data_ok, 1'b1);

    // reset in DATA drops the transaction
    do_reset();
    d_wr = 0; d_size = 2; d_addr = 32'h2000_0000;
    step(0, 1, 0, 0, 32'h0, 0);
    step(0, 1, 1, 0, 32'h0, 0);
    step(0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 1, 32'h0, 0);
    chk("t6 m_req", m_req, 1'b0);
    chk("t6 d_data_ok", d_data_ok, 1'b0);
    chk("t6 i_data_ok", i_data_ok, 1'b0);
    step(0, 0, 0, 0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
